// File: rtl/vend_pkg.sv
// Shared definitions for the vending change path.
//   - coin codes as carried on refill_coin / eject_coin
//   - coin face values in cents
//   - dispenser state encoding
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'd0,
        COIN_DIME    = 2'd1,
        COIN_QUARTER = 2'd2,
        COIN_DOLLAR  = 2'd3
    } coin_e;

    localparam int unsigned DIME_CENTS    = 10;
    localparam int unsigned QUARTER_CENTS = 25;
    localparam int unsigned DOLLAR_CENTS  = 100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_GAP,
        ST_DONE,
        ST_JAM
    } disp_state_e;

    function automatic int unsigned coin_value(input coin_e coin);
        case (coin)
            COIN_DIME:    return DIME_CENTS;
            COIN_QUARTER: return QUARTER_CENTS;
            COIN_DOLLAR:  return DOLLAR_CENTS;
            default:      return 0;
        endcase
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-coin stock counters for the change hopper.
//   clk, rst_n          clock, asynchronous active-low reset
//   refill_valid        add refill_count coins of type refill_coin (code 0 ignored)
//   refill_coin         coin code 0 none, 1 dime, 2 quarter, 3 dollar
//   refill_count        number of coins added; counters saturate at all-ones
//   dec                 one-hot decrement: bit0 dime, bit1 quarter, bit2 dollar
//   inv_dime/quarter/dollar  current counts
// A refill and a decrement of the same coin in one cycle saturate first,
// then subtract one.
module coin_inventory
    import vend_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             refill_valid,
    input  logic [1:0]       refill_coin,
    input  logic [CNT_W-1:0] refill_count,
    input  logic [2:0]       dec,
    output logic [CNT_W-1:0] inv_dime,
    output logic [CNT_W-1:0] inv_quarter,
    output logic [CNT_W-1:0] inv_dollar
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [CNT_W-1:0] add   [3];
    logic [CNT_W:0]   sum   [3];
    logic [CNT_W-1:0] sat   [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
            add[i] = '0;
            if (refill_valid && (refill_coin == 2'(i + 1))) begin
                add[i] = refill_count;
            end
            sum[i] = {1'b0, cnt_q[i]} + {1'b0, add[i]};
            sat[i] = (sum[i] > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[i][CNT_W-1:0];
            // The zero guard never fires in practice because SELECT only picks
            // stocked coins; it keeps the counter from wrapping regardless.
            cnt_d[i] = (dec[i] && (sat[i] != '0)) ? (sat[i] - CNT_W'(1)) : sat[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign inv_dime    = cnt_q[0];
    assign inv_quarter = cnt_q[1];
    assign inv_dollar  = cnt_q[2];

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change dispenser sequencer.
// Takes a change amount over req_valid/req_ready, then ejects coins largest
// first (limited by stock) over eject_valid/eject_ack, one at a time with a
// settling gap between coins. A coin not acknowledged within ACK_TIMEOUT
// cycles raises a sticky jam that blocks new requests until clear_jam.
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready/req_amount    change request in cents
//   refill_valid/coin/count           inventory refill, accepted in any state
//   eject_valid/eject_coin/eject_ack  hopper handshake
//   clear_jam                         operator jam clear
//   busy, done                        request in progress, completion pulse
//   dispensed, residue                cents returned / not returned, last request
//   jam                               sticky jam flag
//   inv_dime/quarter/dollar           current coin counts
module change_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int AMT_W       = 10,
    parameter int CNT_W       = 8,
    parameter int ACK_TIMEOUT = 255,
    parameter int GAP_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    input  logic             refill_valid,
    input  logic [1:0]       refill_coin,
    input  logic [CNT_W-1:0] refill_count,
    output logic             eject_valid,
    output logic [1:0]       eject_coin,
    input  logic             eject_ack,
    input  logic             clear_jam,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] dispensed,
    output logic [AMT_W-1:0] residue,
    output logic             jam,
    output logic [CNT_W-1:0] inv_dime,
    output logic [CNT_W-1:0] inv_quarter,
    output logic [CNT_W-1:0] inv_dollar
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);

    disp_state_e      state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [AMT_W-1:0] dispensed_q, dispensed_d;
    logic [AMT_W-1:0] residue_q, residue_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    coin_e            coin_q, coin_d;
    logic             eject_valid_q, eject_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             jam_q, jam_d;

    coin_e            sel_coin;
    logic [AMT_W-1:0] coin_val;
    logic             take;
    logic [2:0]       dec;

    // A coin is consumed only on an ack while the eject is actually offered.
    assign take     = (state_q == ST_EJECT) && eject_ack;
    assign dec      = take ? {coin_q == COIN_DOLLAR, coin_q == COIN_QUARTER, coin_q == COIN_DIME}
                           : 3'b000;
    assign coin_val = AMT_W'(coin_value(coin_q));

    coin_inventory #(
        .CNT_W (CNT_W)
    ) u_inventory (
        .clk          (clk),
        .rst_n        (rst_n),
        .refill_valid (refill_valid),
        .refill_coin  (refill_coin),
        .refill_count (refill_count),
        .dec          (dec),
        .inv_dime     (inv_dime),
        .inv_quarter  (inv_quarter),
        .inv_dollar   (inv_dollar)
    );

    // Greedy pick: largest stocked coin that does not overshoot. No
    // backtracking, so e.g. 30 cents with quarters stocked leaves 5 residue.
    always_comb begin
        sel_coin = COIN_NONE;
        if ((remaining_q >= AMT_W'(DOLLAR_CENTS)) && (inv_dollar != '0)) begin
            sel_coin = COIN_DOLLAR;
        end else if ((remaining_q >= AMT_W'(QUARTER_CENTS)) && (inv_quarter != '0)) begin
            sel_coin = COIN_QUARTER;
        end else if ((remaining_q >= AMT_W'(DIME_CENTS)) && (inv_dime != '0)) begin
            sel_coin = COIN_DIME;
        end
    end

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        dispensed_d   = dispensed_q;
        residue_d     = residue_q;
        tmo_d         = tmo_q;
        gap_d         = gap_q;
        coin_d        = coin_q;
        eject_valid_d = eject_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        jam_d         = jam_q && !clear_jam;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    remaining_d = req_amount;
                    dispensed_d = '0;
                    residue_d   = '0;
                    busy_d      = 1'b1;
                    state_d     = ST_SELECT;
                end
            end

            ST_SELECT: begin
                if (sel_coin == COIN_NONE) begin
                    done_d    = 1'b1;
                    residue_d = remaining_q;
                    state_d   = ST_DONE;
                end else begin
                    coin_d        = sel_coin;
                    eject_valid_d = 1'b1;
                    tmo_d         = '0;
                    state_d       = ST_EJECT;
                end
            end

            ST_EJECT: begin
                if (eject_ack) begin
                    remaining_d   = remaining_q - coin_val;
                    dispensed_d   = dispensed_q + coin_val;
                    eject_valid_d = 1'b0;
                    gap_d         = '0;
                    state_d       = (GAP_CYCLES == 0) ? ST_SELECT : ST_GAP;
                end else if (int'(tmo_q) >= ACK_TIMEOUT - 1) begin
                    // eject_valid has now been high ACK_TIMEOUT cycles.
                    eject_valid_d = 1'b0;
                    jam_d         = 1'b1;
                    done_d        = 1'b1;
                    residue_d     = remaining_q;
                    state_d       = ST_JAM;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_GAP: begin
                if (int'(gap_q) >= GAP_CYCLES - 1) begin
                    state_d = ST_SELECT;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            ST_DONE, ST_JAM: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            dispensed_q   <= '0;
            residue_q     <= '0;
            tmo_q         <= '0;
            gap_q         <= '0;
            coin_q        <= COIN_NONE;
            eject_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            jam_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            dispensed_q   <= dispensed_d;
            residue_q     <= residue_d;
            tmo_q         <= tmo_d;
            gap_q         <= gap_d;
            coin_q        <= coin_d;
            eject_valid_q <= eject_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            jam_q         <= jam_d;
        end
    end

    // Gated by rst_n so the controller never advertises readiness while reset
    // is held, yet is ready immediately on release.
    assign req_ready   = rst_n && (state_q == ST_IDLE) && !jam_q;
    assign eject_valid = eject_valid_q;
    assign eject_coin  = coin_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dispensed   = dispensed_q;
    assign residue     = residue_q;
    assign jam         = jam_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Scoreboard bench for change_dispense_ctrl: directed scenarios followed by
// randomized requests against a greedy change model.
module tb_change_dispense_ctrl;

    localparam int AMT_W       = 10;
    localparam int CNT_W       = 8;
    localparam int ACK_TIMEOUT = 16;
    localparam int GAP_CYCLES  = 2;
    localparam int CNT_SAT     = 255;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [AMT_W-1:0] req_amount;
    logic             refill_valid;
    logic [1:0]       refill_coin;
    logic [CNT_W-1:0] refill_count;
    logic             eject_valid;
    logic [1:0]       eject_coin;
    logic             eject_ack;
    logic             clear_jam;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] dispensed;
    logic [AMT_W-1:0] residue;
    logic             jam;
    logic [CNT_W-1:0] inv_dime;
    logic [CNT_W-1:0] inv_quarter;
    logic [CNT_W-1:0] inv_dollar;

    change_dispense_ctrl #(
        .AMT_W       (AMT_W),
        .CNT_W       (CNT_W),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_amount   (req_amount),
        .refill_valid (refill_valid),
        .refill_coin  (refill_coin),
        .refill_count (refill_count),
        .eject_valid  (eject_valid),
        .eject_coin   (eject_coin),
        .eject_ack    (eject_ack),
        .clear_jam    (clear_jam),
        .busy         (busy),
        .done         (done),
        .dispensed    (dispensed),
        .residue      (residue),
        .jam          (jam),
        .inv_dime     (inv_dime),
        .inv_quarter  (inv_quarter),
        .inv_dollar   (inv_dollar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int disp;
        int res;
        bit jam;
        int inv_d;
        int inv_q;
        int inv_l;
    } rec_t;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   coin_cents [4] = '{0, 10, 25, 100};
    int   minv [4];
    int   exp_coins [$];
    rec_t exp_recs [$];
    rec_t mon_r;

    // hopper model controls
    bit hop_stall   = 1'b0;
    bit spurious_en = 1'b0;
    int ack_delay   = 1;
    int wait_cnt    = 0;

    // monitor state
    bit prev_valid      = 1'b0;
    int low_len         = 0;
    int hi_len          = 0;
    int last_hi_len     = 0;
    int ejects_in_req   = 0;
    int first_eject_cyc = 0;
    int done_cyc        = 0;
    int done_cnt        = 0;
    int acc_cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Hopper: acks ack_delay cycles after eject_valid appears, never while
    // stalled, and optionally pulses stray acks while nothing is offered.
    always @(negedge clk) begin
        if (!eject_valid) begin
            wait_cnt  = 0;
            eject_ack = spurious_en && ($urandom_range(0, 3) == 0);
        end else if (hop_stall) begin
            eject_ack = 1'b0;
        end else if (wait_cnt >= ack_delay) begin
            eject_ack = 1'b1;
        end else begin
            eject_ack = 1'b0;
            wait_cnt++;
        end
    end

    // Monitor: pops expected coins on each new eject and expected results on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            low_len    = 0;
            hi_len     = 0;
        end else begin
            if (eject_valid) begin
                if (!prev_valid) begin
                    check("eject_expected", exp_coins.size() > 0, 1);
                    if (exp_coins.size() > 0) begin
                        check("eject_coin", eject_coin, exp_coins.pop_front());
                    end
                    if (ejects_in_req == 0) begin
                        first_eject_cyc = cyc;
                    end else begin
                        check("gap_between_coins", low_len, GAP_CYCLES + 1);
                    end
                    ejects_in_req++;
                    hi_len = 0;
                end
                hi_len++;
                low_len = 0;
            end else begin
                if (prev_valid) last_hi_len = hi_len;
                low_len++;
            end
            prev_valid = eject_valid;

            if (done) begin
                check("done_expected", exp_recs.size() > 0, 1);
                if (exp_recs.size() > 0) begin
                    mon_r = exp_recs.pop_front();
                    check("dispensed", dispensed, mon_r.disp);
                    check("residue", residue, mon_r.res);
                    check("jam_at_done", jam, mon_r.jam);
                    check("inv_dime", inv_dime, mon_r.inv_d);
                    check("inv_quarter", inv_quarter, mon_r.inv_q);
                    check("inv_dollar", inv_dollar, mon_r.inv_l);
                    check("coins_outstanding", exp_coins.size(), 0);
                end
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_refill(input int coin, input int cnt);
        step();
        refill_valid = 1'b1;
        refill_coin  = 2'(coin);
        refill_count = CNT_W'(cnt);
        step();
        refill_valid = 1'b0;
        refill_coin  = '0;
        refill_count = '0;
        if (coin != 0) minv[coin] = (minv[coin] + cnt > CNT_SAT) ? CNT_SAT : minv[coin] + cnt;
    endtask

    // Greedy reference: largest stocked coin not exceeding what is left.
    // With jam_first the first chosen coin is never acknowledged.
    task automatic send_req(input int amt, input bit jam_first);
        int   n;
        int   rem;
        int   disp;
        int   c;
        rec_t r;
        step();
        req_valid  = 1'b1;
        req_amount = AMT_W'(amt);
        n = 0;
        while (!req_ready && n < 200) begin
            step();
            n++;
        end
        check("req_accepted", req_ready, 1);
        acc_cyc       = cyc;
        ejects_in_req = 0;
        rem  = amt;
        disp = 0;
        while (1) begin
            c = 0;
            for (int k = 3; k >= 1; k--) begin
                if (c == 0 && coin_cents[k] <= rem && minv[k] > 0) c = k;
            end
            if (c == 0) break;
            exp_coins.push_back(c);
            if (jam_first) break;
            rem  -= coin_cents[c];
            disp += coin_cents[c];
            minv[c]--;
        end
        r.disp  = disp;
        r.res   = rem;
        r.jam   = jam_first;
        r.inv_d = minv[1];
        r.inv_q = minv[2];
        r.inv_l = minv[3];
        exp_recs.push_back(r);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit exp_jam);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            step();
            n++;
        end
        check("done_seen", done_cnt != start, 1);
        step();
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("ready_after_done", req_ready, !exp_jam);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        int amt;
        int n;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_amount   = '0;
        refill_valid = 1'b0;
        refill_coin  = '0;
        refill_count = '0;
        eject_ack    = 1'b0;
        clear_jam    = 1'b0;
        for (int i = 0; i < 4; i++) minv[i] = 0;

        // reset state
        #3;
        check("rst_req_ready", req_ready, 0);
        check("rst_eject_valid", eject_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_jam", jam, 0);
        check("rst_dispensed", dispensed, 0);
        check("rst_residue", residue, 0);
        check("rst_inv_dime", inv_dime, 0);
        check("rst_inv_quarter", inv_quarter, 0);
        check("rst_inv_dollar", inv_dollar, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("ready_after_reset", req_ready, 1);

        // 135 cents from 5/5/5: dollar, quarter, dime
        for (int c = 1; c <= 3; c++) do_refill(c, 5);
        ack_delay = 1;
        send_req(135, 1'b0);
        wait_done(300, 1'b0);

        // drain dollars, then 100 cents from quarters only
        send_req(400, 1'b0);
        wait_done(300, 1'b0);
        do_refill(2, 4);
        send_req(100, 1'b0);
        wait_done(300, 1'b0);
        check("first_eject_latency", first_eject_cyc - acc_cyc, 2);

        // nothing payable: 5 cents, then 0 cents
        for (int c = 1; c <= 3; c++) do_refill(c, 10);
        send_req(5, 1'b0);
        wait_done(50, 1'b0);
        check("no_coin_done_latency", done_cyc - acc_cyc, 2);
        check("no_coin_ejects", ejects_in_req, 0);
        send_req(0, 1'b0);
        wait_done(50, 1'b0);
        check("zero_done_latency", done_cyc - acc_cyc, 2);
        check("zero_ejects", ejects_in_req, 0);

        // jam: hopper never acks
        hop_stall = 1'b1;
        send_req(50, 1'b1);
        wait_done(100, 1'b1);
        check("jam_valid_cycles", last_hi_len, ACK_TIMEOUT);
        repeat (5) step();
        check("jam_sticky", jam, 1);
        check("jam_blocks_ready", req_ready, 0);
        clear_jam = 1'b1;
        step();
        clear_jam = 1'b0;
        check("jam_cleared", jam, 0);
        check("ready_after_clear", req_ready, 1);
        hop_stall = 1'b0;

        // asynchronous reset in the middle of an eject
        hop_stall = 1'b1;
        send_req(50, 1'b0);
        n = 0;
        while (!eject_valid && n < 20) begin
            step();
            n++;
        end
        check("eject_before_reset", eject_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_eject_valid", eject_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_ready", req_ready, 0);
        check("async_rst_inv_dime", inv_dime, 0);
        check("async_rst_inv_quarter", inv_quarter, 0);
        check("async_rst_inv_dollar", inv_dollar, 0);
        exp_coins.delete();
        exp_recs.delete();
        for (int i = 0; i < 4; i++) minv[i] = 0;
        hop_stall = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("ready_after_async_reset", req_ready, 1);

        // refill of 3 dimes lands in the same cycle as a dime ack: 2 + 3 - 1
        ack_delay = 1;
        do_refill(1, 2);
        minv[1] += 3;  // the concurrent refill below, folded in up front
        send_req(10, 1'b0);
        n = 0;
        while (!eject_valid && n < 20) begin
            step();
            n++;
        end
        step();
        refill_valid = 1'b1;
        refill_coin  = 2'd1;
        refill_count = CNT_W'(3);
        step();
        refill_valid = 1'b0;
        refill_coin  = '0;
        refill_count = '0;
        wait_done(100, 1'b0);
        check("refill_with_dec_dime", inv_dime, 4);

        // saturation
        do_refill(1, 246);
        check("dime_250", inv_dime, 250);
        do_refill(1, 255);
        check("dime_saturated", inv_dime, 255);

        // randomized requests
        spurious_en = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) do_refill($urandom_range(0, 3), $urandom_range(0, 6));
            ack_delay = $urandom_range(0, 4);
            amt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 300);
            send_req(amt, 1'b0);
            wait_done(3000, 1'b0);
        end
        spurious_en = 1'b0;

        check("final_coins_queue", exp_coins.size(), 0);
        check("final_recs_queue", exp_recs.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
Sequences the coin hopper that returns change after a purchase or a cancel. It accepts a change amount in cents from the vending FSM through a valid/ready handshake. It then ejects coins one at a time (largest coin first, limited by what is in stock) over a valid/ack handshake to the hopper. It tracks per-coin inventory, detects hopper jams by timeout, and reports the amount dispensed plus any residue it could not return.

Parameters:
AMT_W, 10, width of cent amounts (maximum 1023 cents)
CNT_W, 8, width of each coin inventory counter
ACK_TIMEOUT, 255, maximum number of cycles eject_valid may stay high without eject_ack before a jam is declared (minimum 1)
GAP_CYCLES, 2, idle cycles between coins for hopper settling (0 allowed)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  change request valid
req_ready  out  1  controller can accept a request
req_amount  in  AMT_W  change to return, in cents
refill_valid  in  1  add coins to inventory
refill_coin  in  2  coin code: 0 none, 1 dime, 2 quarter, 3 dollar
refill_count  in  CNT_W  number of coins added
eject_valid  out  1  hopper eject request
eject_coin  out  2  coin code to eject; stable while eject_valid is high
eject_ack  in  1  hopper has ejected the coin
clear_jam  in  1  operator clears jam
busy  out  1  request in progress
done  out  1  one-cycle completion pulse
dispensed  out  AMT_W  cents returned for the last request
residue  out  AMT_W  cents not returned for the last request
jam  out  1  sticky hopper-jam flag
inv_dime, inv_quarter, inv_dollar  out  CNT_W each  current coin counts

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (req_ready is 0 only while reset is held); inventories 0. Reset mid-eject drops eject_valid immediately and abandons the request.
- Coin values are 10, 25 and 100 cents.
- States: IDLE, SELECT, EJECT, GAP, DONE, JAM.
- IDLE: req_ready = 1 if not jam. Accept on req_valid && req_ready in cycle T:
  - latch remaining = req_amount;
  - clear dispensed and residue;
  - busy=1 from T+1 until DONE exits.
- SELECT (one cycle): pick the largest coin with value <= remaining and inventory > 0. Selection is greedy with no backtracking, so remaining 30 with quarters in stock gives 25 + 5 residue.
  - If remaining = 0 or no coin qualifies: go to DONE.
  - Otherwise: go to EJECT.
  - First eject_valid is at T+2.
- EJECT: eject_valid=1 with eject_coin held. Timeout counter starts at 0 on entry.
  - eject_ack in any EJECT cycle:
    - remaining -= value, dispensed += value;
    - decrement that coin's inventory;
    - go to GAP, or to SELECT if GAP_CYCLES=0.
  - No ack within ACK_TIMEOUT cycles (eject_valid high exactly ACK_TIMEOUT cycles): go to JAM. An ack in the last cycle counts as success.
  - eject_ack while eject_valid=0 is ignored.
- GAP: GAP_CYCLES cycles with eject_valid=0, then SELECT.
- DONE (one cycle): done=1, residue=remaining, busy=0 next cycle, then IDLE. dispensed and residue hold until the next accept.
- JAM: eject_valid drops and jam=1 in the same cycle; done pulses once with residue=remaining. Then IDLE with jam held and req_ready=0. clear_jam clears jam the next cycle. The jammed coin's inventory is not decremented.
- Refill is accepted in any state (including JAM) and adds refill_count, saturating at 2^CNT_W-1. Code 0 is ignored.
- Refill and decrement of the same coin in the same cycle: new value = sat(old + count) - 1, computed before the decrement. Inventory never underflows, because SELECT requires count > 0.
- All arithmetic is unsigned. remaining never goes below 0, by selection rule.

Decomposition:
- Shared package vend_pkg:
  - coin code constants (COIN_NONE, COIN_DIME, COIN_QUARTER, COIN_DOLLAR);
  - coin value constants (10/25/100);
  - dispenser state enum.
- One sub-module, coin_inventory: three saturating counters with refill port, one-hot decrement, and count outputs. The FSM, timeout counter and gap counter stay in change_dispense_ctrl.

Test Plan:
- Refill 5 of each coin; req 135; ack 1 cycle after each eject_valid -> ejects dollar, quarter, dime in order; done with dispensed=135, residue=0; inventory 4/4/4.
- Dollar inventory 0, quarters 8; req 100 -> four quarter ejects; dispensed=100; inv_quarter=4; first eject_valid exactly 2 cycles after accept.
- Full inventory; req 5, then req 0 -> no eject_valid in either case; done 2 cycles after accept; residue=5 and 0 respectively.
- ACK_TIMEOUT=16; req 50; never ack -> eject_valid high exactly 16 cycles, then jam=1 and done with residue=50. req_ready stays 0 until clear_jam, then returns to 1.
- inv_dime=2; refill dime count 3 in the same cycle as a dime ack -> inv_dime=4. Refill 255 on 250 -> 255 (saturates).
- rst_n low during EJECT -> eject_valid, busy, done and inventories 0 asynchronously (before the next clk edge); after release, req_ready=1.
